// File: rtl/axi2ahb_wdata_if.sv
// AXI W/B channel and AHB write-data signals shared between the bridge
// write-data path (slave) and whatever drives the AXI/AHB side (master).
interface axi2ahb_wdata_if #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_DATA_WIDTH-1:0]   WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                        WLAST;
    logic                        WVALID;
    logic                        WREADY;
    logic [AXI_ID_WIDTH-1:0]     BID;
    logic [1:0]                  BRESP;
    logic                        BVALID;
    logic                        BREADY;
    logic [AXI_DATA_WIDTH-1:0]   HWDATA;
    logic                        HREADY;
    logic                        HRESP;

    modport slave (
        input  WDATA, WSTRB, WLAST, WVALID, BREADY, HREADY, HRESP,
        output WREADY, BID, BRESP, BVALID, HWDATA
    );

    modport master (
        output WDATA, WSTRB, WLAST, WVALID, BREADY, HREADY, HRESP,
        input  WREADY, BID, BRESP, BVALID, HWDATA
    );
endinterface

// File: rtl/axi2ahb_wdata.sv
// Write-data path of the AXI-to-AHB bridge: buffers W beats for the AHB data
// phase, folds AHB/command errors per burst and queues one B response per burst.
module axi2ahb_wdata #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int WDATA_DEPTH    = 8,
    parameter int BRESP_DEPTH    = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    axi2ahb_wdata_if.slave          bus,
    input  logic [AXI_ID_WIDTH-1:0] cmd_id_i,
    input  logic                    cmd_error_i,
    output logic                    ctrl_wdata_ready_o,
    input  logic                    ctrl_wdata_valid_i,
    input  logic                    ctrl_wdata_last_i
);
    localparam int WAW = $clog2(WDATA_DEPTH);
    localparam int BAW = $clog2(BRESP_DEPTH);
    localparam int WEW = AXI_DATA_WIDTH + 1;
    localparam int BEW = AXI_ID_WIDTH + 2;
    localparam logic [WAW:0] W_FULL_CNT = (WAW+1)'(WDATA_DEPTH);
    localparam logic [BAW:0] B_FULL_CNT = (BAW+1)'(BRESP_DEPTH);

    logic [WEW-1:0] w_mem [WDATA_DEPTH];
    logic [WAW-1:0] w_wr_ptr, w_rd_ptr;
    logic [WAW:0]   w_count;
    logic           w_full, w_empty, w_push;
    logic [WEW-1:0] w_head;
    logic           head_last;

    logic [BEW-1:0] b_mem [BRESP_DEPTH];
    logic [BAW-1:0] b_wr_ptr, b_rd_ptr;
    logic [BAW:0]   b_count;
    logic           b_full, b_empty, b_push, b_pop;
    logic [BEW-1:0] b_head;
    logic [BEW-1:0] b_entry;

    logic           pop;
    logic           err_q;
    logic           err_now;
    logic           beat_err;
    logic           unused_wstrb;

    // Strobes are not needed: HSIZE from the address path already sizes the transfer.
    assign unused_wstrb = ^bus.WSTRB;

    assign w_full    = (w_count == W_FULL_CNT);
    assign w_empty   = (w_count == '0);
    assign w_push    = bus.WVALID && !w_full;
    assign w_head    = w_mem[w_rd_ptr];
    assign head_last = w_head[0];

    assign b_full  = (b_count == B_FULL_CNT);
    assign b_empty = (b_count == '0);
    assign b_head  = b_mem[b_rd_ptr];
    assign b_pop   = !b_empty && bus.BREADY;

    // A beat is only offered when its burst response is guaranteed a B slot.
    assign ctrl_wdata_ready_o = !w_empty && !b_full;
    assign pop    = ctrl_wdata_valid_i && bus.HREADY && ctrl_wdata_ready_o;
    assign b_push = pop && ctrl_wdata_last_i;

    assign err_now  = cmd_error_i
                   || (bus.HRESP && ctrl_wdata_valid_i)
                   || (pop && (head_last != ctrl_wdata_last_i));
    assign beat_err = err_q || err_now;
    assign b_entry  = {cmd_id_i, (beat_err ? 2'b10 : 2'b00)};

    assign bus.WREADY = !w_full;
    assign bus.HWDATA = w_empty ? '0 : w_head[WEW-1:1];
    assign bus.BVALID = !b_empty;
    assign bus.BID    = b_empty ? '0 : b_head[BEW-1:2];
    assign bus.BRESP  = b_empty ? 2'b00 : b_head[1:0];

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            w_mem[w_wr_ptr] <= {bus.WDATA, bus.WLAST};
        end
        if (b_push) begin
            b_mem[b_wr_ptr] <= b_entry;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_wr_ptr <= '0;
            w_rd_ptr <= '0;
            w_count  <= '0;
        end else begin
            if (w_push) begin
                w_wr_ptr <= w_wr_ptr + WAW'(1);
            end
            if (pop) begin
                w_rd_ptr <= w_rd_ptr + WAW'(1);
            end
            case ({w_push, pop})
                2'b10:   w_count <= w_count + (WAW+1)'(1);
                2'b01:   w_count <= w_count - (WAW+1)'(1);
                default: w_count <= w_count;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            b_wr_ptr <= '0;
            b_rd_ptr <= '0;
            b_count  <= '0;
        end else begin
            if (b_push) begin
                b_wr_ptr <= b_wr_ptr + BAW'(1);
            end
            if (b_pop) begin
                b_rd_ptr <= b_rd_ptr + BAW'(1);
            end
            case ({b_push, b_pop})
                2'b10:   b_count <= b_count + (BAW+1)'(1);
                2'b01:   b_count <= b_count - (BAW+1)'(1);
                default: b_count <= b_count;
            endcase
        end
    end

    // The last beat hands the accumulated status to the B entry, so clearing wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_q <= 1'b0;
        end else if (b_push) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi2ahb_wdata.sv
// Directed self-checking bench for axi2ahb_wdata: inputs change on the falling
// edge, outputs are inspected on the falling edge after each rising edge.
module tb_axi2ahb_wdata;
    logic       ACLK;
    logic       ARESETN;
    logic [0:0] cmd_id_i;
    logic       cmd_error_i;
    logic       ctrl_wdata_ready_o;
    logic       ctrl_wdata_valid_i;
    logic       ctrl_wdata_last_i;

    int checks = 0;
    int errors = 0;

    axi2ahb_wdata_if #(.AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32)) bus ();

    axi2ahb_wdata #(
        .AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32), .WDATA_DEPTH(8), .BRESP_DEPTH(4)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .bus(bus),
        .cmd_id_i(cmd_id_i),
        .cmd_error_i(cmd_error_i),
        .ctrl_wdata_ready_o(ctrl_wdata_ready_o),
        .ctrl_wdata_valid_i(ctrl_wdata_valid_i),
        .ctrl_wdata_last_i(ctrl_wdata_last_i)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic push_beat(input logic [31:0] d, input logic last);
        bus.WDATA  = d;
        bus.WLAST  = last;
        bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    task automatic pop_beat(input logic last, input logic id);
        ctrl_wdata_valid_i = 1'b1;
        ctrl_wdata_last_i  = last;
        cmd_id_i           = id;
        bus.HREADY         = 1'b1;
        tick();
        ctrl_wdata_valid_i = 1'b0;
        ctrl_wdata_last_i  = 1'b0;
    endtask

    task automatic b_handshake();
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        tick();
        tick();
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_bvalid: got %b want 0", bus.BVALID); end
        checks++; if (bus.BID !== 1'b0) begin errors++; $display("[TB] FAIL reset_bid: got %b want 0", bus.BID); end
        checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("[TB] FAIL reset_bresp: got %b want 00", bus.BRESP); end
        checks++; if (bus.HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_hwdata: got %h want 0", bus.HWDATA); end
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl_ready: got %b want 0", ctrl_wdata_ready_o); end
        checks++; if (bus.WREADY !== 1'b1) begin errors++; $display("[TB] FAIL reset_wready: got %b want 1", bus.WREADY); end
        ARESETN = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        push_beat(32'h11, 1'b0);
        checks++; if (ctrl_wdata_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL single_first_ready: got %b want 1", ctrl_wdata_ready_o); end
        checks++; if (bus.HWDATA !== 32'h11) begin errors++; $display("[TB] FAIL single_first_hwdata: got %h want 11", bus.HWDATA); end
        push_beat(32'h22, 1'b0);
        push_beat(32'h33, 1'b0);
        push_beat(32'h44, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.HWDATA !== 32'(17 * (i + 1))) begin errors++; $display("[TB] FAIL single_hwdata[%0d]: got %h want %h", i, bus.HWDATA, 32'(17 * (i + 1))); end
            checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL single_bvalid_early[%0d]: got %b want 0", i, bus.BVALID); end
            pop_beat(i == 3, 1'b1);
        end
        checks++; if (bus.BVALID !== 1'b1) begin errors++; $display("[TB] FAIL single_bvalid: got %b want 1", bus.BVALID); end
        checks++; if (bus.BID !== 1'b1) begin errors++; $display("[TB] FAIL single_bid: got %b want 1", bus.BID); end
        checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("[TB] FAIL single_bresp: got %b want 00", bus.BRESP); end
        b_handshake();
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL single_bvalid_after: got %b want 0", bus.BVALID); end
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL single_ctrl_ready_empty: got %b want 0", ctrl_wdata_ready_o); end
    endtask

    task automatic test_ahb_error();
        push_beat(32'hA1, 1'b0);
        push_beat(32'hA2, 1'b1);
        cmd_id_i           = 1'b0;
        ctrl_wdata_valid_i = 1'b1;
        ctrl_wdata_last_i  = 1'b0;
        bus.HREADY         = 1'b0;
        bus.HRESP          = 1'b1;
        tick();
        checks++; if (bus.HWDATA !== 32'hA1) begin errors++; $display("[TB] FAIL err_hold_hwdata: got %h want a1", bus.HWDATA); end
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP          = 1'b0;
        ctrl_wdata_valid_i = 1'b0;
        checks++; if (bus.HWDATA !== 32'hA2) begin errors++; $display("[TB] FAIL err_next_hwdata: got %h want a2", bus.HWDATA); end
        pop_beat(1'b1, 1'b0);
        checks++; if (bus.BVALID !== 1'b1) begin errors++; $display("[TB] FAIL err_bvalid: got %b want 1", bus.BVALID); end
        checks++; if (bus.BRESP !== 2'b10) begin errors++; $display("[TB] FAIL err_bresp: got %b want 10", bus.BRESP); end
        b_handshake();
        push_beat(32'hA3, 1'b1);
        pop_beat(1'b1, 1'b1);
        checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("[TB] FAIL err_cleared_bresp: got %b want 00", bus.BRESP); end
        checks++; if (bus.BID !== 1'b1) begin errors++; $display("[TB] FAIL err_cleared_bid: got %b want 1", bus.BID); end
        b_handshake();
    endtask

    task automatic test_mismatch();
        push_beat(32'hB1, 1'b0);
        push_beat(32'hB2, 1'b0);
        push_beat(32'hB3, 1'b1);
        pop_beat(1'b0, 1'b0);
        pop_beat(1'b1, 1'b0);
        pop_beat(1'b1, 1'b1);
        checks++; if (bus.BID !== 1'b0) begin errors++; $display("[TB] FAIL mism_bid0: got %b want 0", bus.BID); end
        checks++; if (bus.BRESP !== 2'b10) begin errors++; $display("[TB] FAIL mism_bresp0: got %b want 10", bus.BRESP); end
        b_handshake();
        checks++; if (bus.BID !== 1'b1) begin errors++; $display("[TB] FAIL mism_bid1: got %b want 1", bus.BID); end
        checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("[TB] FAIL mism_bresp1: got %b want 00", bus.BRESP); end
        b_handshake();
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL mism_drained: got %b want 0", bus.BVALID); end
        // A command error outside any data-phase handshake still poisons the burst.
        push_beat(32'hD1, 1'b0);
        push_beat(32'hD2, 1'b1);
        pop_beat(1'b0, 1'b1);
        cmd_error_i = 1'b1;
        tick();
        cmd_error_i = 1'b0;
        pop_beat(1'b1, 1'b1);
        checks++; if (bus.BRESP !== 2'b10) begin errors++; $display("[TB] FAIL cmderr_bresp: got %b want 10", bus.BRESP); end
        checks++; if (bus.BID !== 1'b1) begin errors++; $display("[TB] FAIL cmderr_bid: got %b want 1", bus.BID); end
        b_handshake();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bus.BREADY = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.WDATA  = 32'h100 + 32'(acc);
            bus.WLAST  = (acc == 3) || (acc == 7) || (acc == 9);
            bus.WVALID = 1'b1;
            if (bus.WREADY) acc++;
            tick();
        end
        checks++; if (acc !== 8) begin errors++; $display("[TB] FAIL bp_accepts: got %0d want 8", acc); end
        checks++; if (bus.WREADY !== 1'b0) begin errors++; $display("[TB] FAIL bp_wready_full: got %b want 0", bus.WREADY); end
        checks++; if (bus.HWDATA !== 32'h100) begin errors++; $display("[TB] FAIL bp_head: got %h want 100", bus.HWDATA); end
        // WVALID stays high across the pop: a full FIFO must not take the beat.
        pop_beat(1'b0, 1'b0);
        checks++; if (bus.WREADY !== 1'b1) begin errors++; $display("[TB] FAIL bp_wready_after_pop: got %b want 1", bus.WREADY); end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        for (int k = 1; k < 8; k++) begin
            checks++; if (bus.HWDATA !== 32'h100 + 32'(k)) begin errors++; $display("[TB] FAIL bp_order[%0d]: got %h want %h", k, bus.HWDATA, 32'h100 + 32'(k)); end
            pop_beat((k == 3) || (k == 7), 1'b0);
        end
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_extra_beat: got %b want 0", ctrl_wdata_ready_o); end
        push_beat(32'h108, 1'b0);
        push_beat(32'h109, 1'b1);
        checks++; if (bus.HWDATA !== 32'h108) begin errors++; $display("[TB] FAIL bp_tail8: got %h want 108", bus.HWDATA); end
        pop_beat(1'b0, 1'b0);
        checks++; if (bus.HWDATA !== 32'h109) begin errors++; $display("[TB] FAIL bp_tail9: got %h want 109", bus.HWDATA); end
        pop_beat(1'b1, 1'b0);
        tick();
        bus.BREADY = 1'b0;
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL bp_b_drained: got %b want 0", bus.BVALID); end

        // Four unacknowledged responses fill the B FIFO and stall the next beat.
        for (int k = 0; k < 4; k++) begin
            push_beat(32'h200 + 32'(k), 1'b1);
            pop_beat(1'b1, 1'(k % 2));
        end
        push_beat(32'h204, 1'b1);
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bstall_ready: got %b want 0", ctrl_wdata_ready_o); end
        tick();
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bstall_ready_hold: got %b want 0", ctrl_wdata_ready_o); end
        checks++; if (bus.BID !== 1'b0) begin errors++; $display("[TB] FAIL bstall_bid0: got %b want 0", bus.BID); end
        b_handshake();
        checks++; if (ctrl_wdata_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bstall_release: got %b want 1", ctrl_wdata_ready_o); end
        checks++; if (bus.HWDATA !== 32'h204) begin errors++; $display("[TB] FAIL bstall_hwdata: got %h want 204", bus.HWDATA); end
        pop_beat(1'b1, 1'b0);
        for (int k = 1; k < 5; k++) begin
            checks++; if (bus.BID !== 1'(k % 2)) begin errors++; $display("[TB] FAIL bstall_bid[%0d]: got %b want %b", k, bus.BID, 1'(k % 2)); end
            checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("[TB] FAIL bstall_bresp[%0d]: got %b want 00", k, bus.BRESP); end
            b_handshake();
        end
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL bstall_drained: got %b want 0", bus.BVALID); end
    endtask

    task automatic test_wait_states();
        push_beat(32'hC1, 1'b0);
        push_beat(32'hC2, 1'b1);
        ctrl_wdata_valid_i = 1'b1;
        ctrl_wdata_last_i  = 1'b0;
        cmd_id_i           = 1'b1;
        bus.HREADY         = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            checks++; if (bus.HWDATA !== 32'hC1) begin errors++; $display("[TB] FAIL wait_hwdata[%0d]: got %h want c1", w, bus.HWDATA); end
            checks++; if (ctrl_wdata_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL wait_ready[%0d]: got %b want 1", w, ctrl_wdata_ready_o); end
        end
        bus.HREADY = 1'b1;
        tick();
        ctrl_wdata_valid_i = 1'b0;
        checks++; if (bus.HWDATA !== 32'hC2) begin errors++; $display("[TB] FAIL wait_next: got %h want c2", bus.HWDATA); end
        pop_beat(1'b1, 1'b1);
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL wait_count: got %b want 0", ctrl_wdata_ready_o); end
        checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("[TB] FAIL wait_bresp: got %b want 00", bus.BRESP); end
        b_handshake();
    endtask

    task automatic test_reset_mid_burst();
        push_beat(32'hE0, 1'b1);
        pop_beat(1'b1, 1'b1);
        cmd_error_i = 1'b1;
        push_beat(32'hE1, 1'b0);
        cmd_error_i = 1'b0;
        push_beat(32'hE2, 1'b0);
        push_beat(32'hE3, 1'b0);
        checks++; if (bus.BVALID !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre_bvalid: got %b want 1", bus.BVALID); end
        #2 ARESETN = 1'b0;
        #1;
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL rmid_bvalid: got %b want 0", bus.BVALID); end
        checks++; if (bus.BID !== 1'b0) begin errors++; $display("[TB] FAIL rmid_bid: got %b want 0", bus.BID); end
        checks++; if (bus.HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL rmid_hwdata: got %h want 0", bus.HWDATA); end
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ctrl_ready: got %b want 0", ctrl_wdata_ready_o); end
        checks++; if (bus.WREADY !== 1'b1) begin errors++; $display("[TB] FAIL rmid_wready: got %b want 1", bus.WREADY); end
        tick();
        ARESETN = 1'b1;
        tick();
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL rmid_no_stale_b: got %b want 0", bus.BVALID); end
        checks++; if (ctrl_wdata_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flushed: got %b want 0", ctrl_wdata_ready_o); end
        push_beat(32'hF1, 1'b1);
        pop_beat(1'b1, 1'b0);
        checks++; if (bus.BVALID !== 1'b1) begin errors++; $display("[TB] FAIL rmid_new_bvalid: got %b want 1", bus.BVALID); end
        checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("[TB] FAIL rmid_new_bresp: got %b want 00", bus.BRESP); end
        checks++; if (bus.BID !== 1'b0) begin errors++; $display("[TB] FAIL rmid_new_bid: got %b want 0", bus.BID); end
        b_handshake();
        checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("[TB] FAIL rmid_single_b: got %b want 0", bus.BVALID); end
    endtask

    initial begin
        ARESETN            = 1'b0;
        bus.WDATA          = '0;
        bus.WSTRB          = '1;
        bus.WLAST          = 1'b0;
        bus.WVALID         = 1'b0;
        bus.BREADY         = 1'b0;
        bus.HREADY         = 1'b1;
        bus.HRESP          = 1'b0;
        cmd_id_i           = 1'b0;
        cmd_error_i        = 1'b0;
        ctrl_wdata_valid_i = 1'b0;
        ctrl_wdata_last_i  = 1'b0;
        $display("[TB] starting axi2ahb_wdata directed tests");
        test_reset();
        test_single_burst();
        test_ahb_error();
        test_mismatch();
        test_backpressure();
        test_wait_states();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
